alu_op_sequencer: RTL

- Initiator-side controller for the two-function (ADD/SUB) ALU responder.
- Accepts an operation request over a valid/ready handshake and drives the ALU operand and control inputs from registers.
- Waits a parameterised settle time, then captures the result and N/Z/C/V flags and evaluates a RISC-V branch condition from them.
- Returns result, flags and branch decision over a valid/ready response channel; sits between decode/issue and the ALU in the core.

---
 rtl/alu_op_sequencer_pkg.sv | 38 +++
 rtl/alu_op_sequencer_if.sv | 42 ++++
 rtl/alu_op_sequencer_branch_cond_eval.sv | 22 ++
 rtl/alu_op_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

    // Request opcodes as issued by decode.
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_BEQ  = 3'b010,
        OP_BNE  = 3'b011,
        OP_BLT  = 3'b100,
        OP_BGE  = 3'b101,
        OP_BLTU = 3'b110,
        OP_BGEU = 3'b111
    } op_t;

    // ALU control encodings.
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // Bit positions inside the packed {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Only ADD uses the adder; SUB and every branch compare subtract.
    function automatic logic [1:0] alu_ctrl_for(op_t op);
        return (op == OP_ADD) ? ALU_ADD : ALU_SUB;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, ALU-drive and response signals of the sequencer, bundled.
// slave: the sequencer's view. master: the issuing/ALU environment's view.
interface alu_op_sequencer_if #(
    parameter int N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [1:0]   alu_control;
    logic [N-1:0] alu_result;
    logic         alu_carry;
    logic         alu_overflow;
    logic         alu_zero;
    logic         alu_negative;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_taken;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  alu_result, alu_carry, alu_overflow, alu_zero, alu_negative,
        input  rsp_ready,
        output req_ready, alu_a, alu_b, alu_control,
        output rsp_valid, rsp_result, rsp_flags, rsp_taken
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output alu_result, alu_carry, alu_overflow, alu_zero, alu_negative,
        output rsp_ready,
        input  req_ready, alu_a, alu_b, alu_control,
        input  rsp_valid, rsp_result, rsp_flags, rsp_taken
    );
endinterface

// File: rtl/alu_op_sequencer_branch_cond_eval.sv
// Combinational RISC-V branch condition from the {N,Z,C,V} flags of A-B.
module branch_cond_eval
    import alu_seq_pkg::*;
(
    input  op_t        op,
    input  logic [3:0] flags,
    output logic       taken
);
    // Decode the branch condition; arithmetic ops never branch.
    always_comb begin
        taken = 1'b0;
        unique case (op)
            OP_BEQ:  taken = flags[FLAG_Z];
            OP_BNE:  taken = ~flags[FLAG_Z];
            OP_BLT:  taken = flags[FLAG_N] ^ flags[FLAG_V];
            OP_BGE:  taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
            OP_BLTU: taken = ~flags[FLAG_C];   // C=1 means no borrow
            OP_BGEU: taken = flags[FLAG_C];
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator-side controller for the ADD/SUB ALU: accepts one request, holds
// the ALU inputs for SETTLE cycles (1..15), captures result/flags, evaluates
// the branch condition and returns everything on a valid/ready response.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N      = 32,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus
);
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t       state_reg, state_next;
    op_t          op_reg;
    logic [3:0]   cnt_reg;
    logic [N-1:0] alu_a_reg, alu_b_reg;
    logic [1:0]   alu_ctrl_reg;
    logic [N-1:0] rsp_result_reg;
    logic [3:0]   rsp_flags_reg;
    logic         rsp_taken_reg;

    logic         accept, capture, req_ready, rsp_valid;
    logic [3:0]   flags_now;
    logic         taken_now;

    assign flags_now[FLAG_N] = bus.alu_negative;
    assign flags_now[FLAG_Z] = bus.alu_zero;
    assign flags_now[FLAG_C] = bus.alu_carry;
    assign flags_now[FLAG_V] = bus.alu_overflow;

    // Branch decision from the live ALU flags; only registered at capture.
    branch_cond_eval u_branch_cond_eval (
        .op    (op_reg),
        .flags (flags_now),
        .taken (taken_now)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt_reg == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand/control latch at accept, settle countdown, response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg         <= OP_ADD;
            cnt_reg        <= 4'd0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_ctrl_reg   <= ALU_ADD;
            rsp_result_reg <= '0;
            rsp_flags_reg  <= 4'b0000;
            rsp_taken_reg  <= 1'b0;
        end else begin
            if (accept) begin
                op_reg       <= op_t'(bus.req_op);
                alu_a_reg    <= bus.req_a;
                alu_b_reg    <= bus.req_b;
                alu_ctrl_reg <= alu_ctrl_for(op_t'(bus.req_op));
                cnt_reg      <= CNT_LOAD;
            end else if (state_reg == EXEC && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (capture) begin
                rsp_result_reg <= bus.alu_result;
                rsp_flags_reg  <= flags_now;
                rsp_taken_reg  <= taken_now;
            end
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.alu_a       = alu_a_reg;
    assign bus.alu_b       = alu_b_reg;
    assign bus.alu_control = alu_ctrl_reg;
    assign bus.rsp_result  = rsp_result_reg;
    assign bus.rsp_flags   = rsp_flags_reg;
    assign bus.rsp_taken   = rsp_taken_reg;

endmodule
